// File: rtl/adc_capture.sv
// ADC capture front end: waits for a qualified PLL lock, divides the core clock
// into the ADC sample clock and stores DEPTH words per trigger into a read-back buffer.
module adc_capture #(
    parameter int ADC_BITS    = 10,
    parameter int CLK_DIV     = 4,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_lock,
    input  logic                trig,
    input  logic [ADC_BITS-1:0] adc_data,
    output logic                adc_clk,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     sample_count,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [ADC_BITS-1:0] rd_data,
    output logic                rd_valid,
    output logic [1:0]          state_o
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int SC_W   = ADDR_W + 1;
    localparam int HALF   = CLK_DIV / 2;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_IDLE      = 2'd1,
        S_CAPTURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  lock_meta_q, lock_s_q;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  adc_clk_q, adc_clk_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [SC_W-1:0]       sample_count_q, sample_count_d;
    logic [ADC_BITS-1:0]   rd_data_q;
    logic                  rd_valid_q;
    logic [ADC_BITS-1:0]   mem_q [DEPTH];
    logic                  strobe;
    logic                  write_en;

    // Strobe lands on the cycle adc_clk falls; lock loss masks any write in that cycle.
    assign strobe   = (state_q != S_WAIT_LOCK) && (div_cnt_q == DIV_W'(HALF));
    assign write_en = (state_q == S_CAPTURE) && lock_s_q && strobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_WAIT_LOCK;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_LOCK: if (lock_s_q && lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) state_d = S_IDLE;
            S_IDLE, S_DONE: begin
                if (!lock_s_q)  state_d = S_WAIT_LOCK;
                else if (trig)  state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!lock_s_q) state_d = S_WAIT_LOCK;
                else if (strobe && sample_count_q == SC_W'(DEPTH - 1)) state_d = S_DONE;
            end
            default: state_d = S_WAIT_LOCK;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE) || (state_q == S_DONE);
        busy  = (state_q == S_CAPTURE);
        done  = (state_q == S_DONE);
    end

    always_comb begin
        lock_cnt_d = '0;
        if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK && lock_s_q)
            lock_cnt_d = lock_cnt_q + 1'b1;

        // Divider starts from zero on the first qualified cycle so adc_clk tracks div_cnt exactly.
        div_cnt_d = '0;
        if (state_q != S_WAIT_LOCK && state_d != S_WAIT_LOCK)
            div_cnt_d = (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        adc_clk_d = (state_d != S_WAIT_LOCK) && (div_cnt_d < DIV_W'(HALF));

        wr_addr_d      = wr_addr_q;
        sample_count_d = sample_count_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && state_d == S_CAPTURE) begin
            wr_addr_d      = '0;
            sample_count_d = '0;
        end else if (write_en) begin
            wr_addr_d      = wr_addr_q + 1'b1;
            sample_count_d = sample_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q     <= '0;
            div_cnt_q      <= '0;
            adc_clk_q      <= 1'b0;
            wr_addr_q      <= '0;
            sample_count_q <= '0;
        end else begin
            lock_cnt_q     <= lock_cnt_d;
            div_cnt_q      <= div_cnt_d;
            adc_clk_q      <= adc_clk_d;
            wr_addr_q      <= wr_addr_d;
            sample_count_q <= sample_count_d;
        end
    end

    // Buffer has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (write_en) mem_q[wr_addr_q] <= adc_data;
    end

    // Read handshake: no backpressure; rd_en in cycle N gives rd_valid with
    // rd_data in N+1, and rd_data holds whenever rd_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= mem_q[rd_addr];
        end
    end

    assign adc_clk      = adc_clk_q;
    assign sample_count = sample_count_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: lock qualification, divider pattern, captures,
// retrigger, lock loss and mid-capture reset, with a read-port scoreboard.
module tb_adc_capture;

    localparam int ADC_BITS    = 10;
    localparam int CLK_DIV     = 4;
    localparam int DEPTH       = 256;
    localparam int ADDR_W      = 8;
    localparam int LOCK_CYCLES = 1024;
    localparam int FULL_BUSY   = CLK_DIV * (DEPTH - 1) + 2;
    localparam logic [1:0] ST_WAIT = 2'd0, ST_IDLE = 2'd1, ST_DONE = 2'd3;

    logic                clk = 1'b0;
    logic                reset;
    logic                pll_lock;
    logic                trig;
    logic [ADC_BITS-1:0] adc_data = 10'h3F0;
    logic                adc_clk;
    logic                ready, busy, done;
    logic [ADDR_W:0]     sample_count;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADC_BITS-1:0] rd_data;
    logic                rd_valid;
    logic [1:0]          state;

    int errors = 0;
    int checks = 0;
    logic [ADC_BITS-1:0] exp_q[$];
    int                  exp_addr_q[$];
    logic [ADC_BITS-1:0] exp_mem [DEPTH];
    logic                rd_en_s = 1'b0;

    adc_capture #(
        .ADC_BITS(ADC_BITS), .CLK_DIV(CLK_DIV), .DEPTH(DEPTH),
        .ADDR_W(ADDR_W), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .trig(trig),
        .adc_data(adc_data), .adc_clk(adc_clk), .ready(ready), .busy(busy),
        .done(done), .sample_count(sample_count), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .state_o(state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ADC model: presents a new ramp value on every adc_clk rising edge.
    always @(posedge adc_clk) adc_data = adc_data + 10'd1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) rd_en_s = rd_en;

    always @(negedge clk) begin
        if (rd_en_s || rd_valid) check("rd_valid_timing", 32'(rd_valid), 32'(rd_en_s));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got data %0d expected no read", rd_data);
            end else begin
                check($sformatf("rd_data[%0d]", exp_addr_q.pop_front()), 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_model(input logic [ADC_BITS-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_mem[i] = base + ADC_BITS'(i);
    endtask

    task automatic read_addr(input int a);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(a);
        exp_q.push_back(exp_mem[a]);
        exp_addr_q.push_back(a);
        @(negedge clk);
    endtask

    task automatic read_end(input int last_a);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_data_hold", 32'(rd_data), 32'(exp_mem[last_a]));
    endtask

    task automatic lock_up(input bit pulse_trig);
        logic early;
        early    = 1'b0;
        pll_lock = 1'b1;
        for (int n = 1; n <= LOCK_CYCLES + 2; n++) begin
            @(negedge clk);
            if (pulse_trig && n == 20) trig = 1'b1;
            if (n == 21) trig = 1'b0;
            if (n < LOCK_CYCLES + 2 && (ready !== 1'b0 || adc_clk !== 1'b0)) early = 1'b1;
        end
        check("lock_no_early_ready", 32'(early), 32'd0);
        check("lock_ready_at_1026", 32'(ready), 32'd1);
        check("lock_state_idle", 32'(state), 32'(ST_IDLE));
    endtask

    task automatic run_capture(input int trig_hold, input int stop_count,
                               output logic [ADC_BITS-1:0] base, output int busy_cycles);
        logic prev;
        bit   found;
        bit   hit;
        prev  = adc_clk;
        found = 1'b0;
        for (int k = 0; k < 4 * CLK_DIV; k++) begin
            @(negedge clk);
            if (adc_clk === 1'b1 && prev === 1'b0) begin
                found = 1'b1;
                break;
            end
            prev = adc_clk;
        end
        check("capture_align", 32'(found), 32'd1);
        trig        = 1'b1;
        base        = adc_data;
        busy_cycles = 0;
        hit         = 1'b0;
        for (int n = 1; n <= 1200; n++) begin
            @(negedge clk);
            if (n == trig_hold) trig = 1'b0;
            if (n == 1) begin
                check("capture_entry_busy", 32'(busy), 32'd1);
                check("capture_entry_done", 32'(done), 32'd0);
            end
            if (stop_count > 0 && 32'(sample_count) == stop_count) begin
                hit = 1'b1;
                break;
            end
            if (stop_count == 0 && done === 1'b1) begin
                hit = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
        end
        trig = 1'b0;
        check("capture_reached_end", 32'(hit), 32'd1);
    endtask

    task automatic check_done_state(input int busy_cycles);
        check("busy_cycles", 32'(busy_cycles), 32'(FULL_BUSY));
        check("done_flag", 32'(done), 32'd1);
        check("done_ready", 32'(ready), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_count", 32'(sample_count), 32'(DEPTH));
        check("done_state", 32'(state), 32'(ST_DONE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [ADC_BITS-1:0] base;
        int                  bc;
        int                  list [8];
        bit                  got_ready;

        reset    = 1'b1;
        pll_lock = 1'b0;
        trig     = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'(ST_WAIT));
        check("rst_outputs", 32'({adc_clk, ready, busy, done, rd_valid}), 32'd0);
        check("rst_count", 32'(sample_count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;

        // Lock with a one-cycle glitch: qualification restarts from the last rise.
        pll_lock = 1'b1;
        got_ready = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (ready !== 1'b0 || adc_clk !== 1'b0) got_ready = 1'b1;
        end
        check("lock_glitch_no_ready", 32'(got_ready), 32'd0);
        pll_lock = 1'b0;
        @(negedge clk);
        lock_up(1'b0);

        // Divider pattern in IDLE starting on the first qualified cycle.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("adc_clk_pattern[%0d]", i), 32'(adc_clk), ((i % 4) < 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Capture 1: trig pulse from IDLE, ramp wraps through 1023.
        run_capture(1, 0, base, bc);
        check_done_state(bc);
        fill_model(base, DEPTH);
        for (int a = 0; a < DEPTH; a++) read_addr(a);
        read_end(DEPTH - 1);

        // Capture 2: from DONE with trig held through most of the capture.
        run_capture(1000, 0, base, bc);
        check_done_state(bc);
        fill_model(base, DEPTH);
        list = '{0, 1, 2, 3, 128, 253, 254, 255};
        foreach (list[i]) read_addr(list[i]);
        read_end(255);

        // Capture 3: lock drops after sample 100.
        run_capture(1, 100, base, bc);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        check("loss_state", 32'(state), 32'(ST_WAIT));
        check("loss_flags", 32'({adc_clk, ready, busy, done}), 32'd0);
        check("loss_count", 32'(sample_count), 32'd100);
        fill_model(base, 100);
        repeat (5) @(negedge clk);
        lock_up(1'b1);
        check("loss_count_hold", 32'(sample_count), 32'd100);

        // Capture 4: one-cycle reset after sample 50.
        run_capture(1, 50, base, bc);
        fill_model(base, 50);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(state), 32'(ST_WAIT));
        check("midrst_outputs", 32'({adc_clk, ready, busy, done, rd_valid}), 32'd0);
        check("midrst_count", 32'(sample_count), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;
        got_ready = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got_ready = 1'b1;
                break;
            end
        end
        check("midrst_requalified", 32'(got_ready), 32'd1);
        list = '{0, 10, 49, 50, 99, 100, 200, 255};
        foreach (list[i]) read_addr(list[i]);
        read_end(255);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
